// File: rtl/mdu_if.sv
// Operand, opcode and result bundle between an issuing pipeline and the MDU.
// Signal names match the architectural names used by the pipeline.
interface mdu_if;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [2:0]  MDUop;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output dataA, dataB, MDUop,
    input  busy, HI, LO
  );

  modport slave (
    input  dataA, dataB, MDUop,
    output busy, HI, LO
  );
endinterface

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// Operations are latched in IDLE and their result lands only after a fixed busy window.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic  clk,
  input logic  reset,
  mdu_if.slave bus
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        busy_q;
  logic [2:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        sgn;
  logic        is_div;
  logic [63:0] ma;
  logic [63:0] mb;
  logic [63:0] prod;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] hi_d;
  logic [31:0] lo_d;
  logic        wr_d;

  // Signed ops run as magnitude arithmetic, so 0x80000000 / -1 simply wraps.
  always_comb begin
    sgn    = (op_q == OP_MULT) || (op_q == OP_DIV);
    is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);
    ma     = sgn ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    mb     = sgn ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    prod   = ma * mb;
    a_neg  = sgn & a_q[31];
    b_neg  = sgn & b_q[31];
    a_mag  = a_neg ? (32'd0 - a_q) : a_q;
    b_mag  = b_neg ? (32'd0 - b_q) : b_q;
    uq     = (b_mag != 32'd0) ? (a_mag / b_mag) : 32'd0;
    ur     = (b_mag != 32'd0) ? (a_mag % b_mag) : 32'd0;
    hi_d   = prod[63:32];
    lo_d   = prod[31:0];
    wr_d   = 1'b1;
    if (is_div) begin
      lo_d = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
      hi_d = a_neg ? (32'd0 - ur) : ur;
      wr_d = (b_q != 32'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          case (bus.MDUop)
            OP_MULT, OP_MULTU: begin
              op_q    <= bus.MDUop;
              a_q     <= bus.dataA;
              b_q     <= bus.dataB;
              cnt_q   <= 4'(MULT_CYCLES);
              busy_q  <= 1'b1;
              state_q <= RUN;
            end
            OP_DIV, OP_DIVU: begin
              op_q    <= bus.MDUop;
              a_q     <= bus.dataA;
              b_q     <= bus.dataB;
              cnt_q   <= 4'(DIV_CYCLES);
              busy_q  <= 1'b1;
              state_q <= RUN;
            end
            OP_MTHI: hi_q <= bus.dataA;
            OP_MTLO: lo_q <= bus.dataA;
            default: ;
          endcase
        end
        RUN: begin
          // MDUop is deliberately not looked at here: requests while busy are dropped.
          if (cnt_q == 4'd1) begin
            if (wr_d) begin
              hi_q <= hi_d;
              lo_q <= lo_d;
            end
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed scenarios followed by random ops,
// compared against an arithmetic model of HI/LO and the busy window length.
module tb_mdu;
  localparam int MC = 5;
  localparam int DC = 10;
  localparam logic [2:0] NONE  = 3'd0;
  localparam logic [2:0] MULT  = 3'd1;
  localparam logic [2:0] MULTU = 3'd2;
  localparam logic [2:0] DIV   = 3'd3;
  localparam logic [2:0] DIVU  = 3'd4;
  localparam logic [2:0] MTHI  = 3'd5;
  localparam logic [2:0] MTLO  = 3'd6;
  localparam logic [2:0] BAD   = 3'd7;

  logic clk = 1'b0;
  logic reset;
  mdu_if bus();

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, q, r;
    logic [63:0] u;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    case (op)
      MULT: begin
        p = sa * sb;
        hi_m = p[63:32];
        lo_m = p[31:0];
      end
      MULTU: begin
        u = {32'd0, a} * {32'd0, b};
        hi_m = u[63:32];
        lo_m = u[31:0];
      end
      DIV: if (b != 32'd0) begin
        q = sa / sb;
        r = sa % sb;
        lo_m = q[31:0];
        hi_m = r[31:0];
      end
      DIVU: if (b != 32'd0) begin
        lo_m = a / b;
        hi_m = a % b;
      end
      MTHI: hi_m = a;
      MTLO: lo_m = a;
      default: ;
    endcase
  endtask

  // Issue a multi-cycle op, measure busy length, check HI/LO hold and final result.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag, input bit inject);
    int n;
    int exp_n;
    logic [31:0] hi_old;
    logic [31:0] lo_old;
    hi_old = hi_m;
    lo_old = lo_m;
    exp_n = (op == MULT || op == MULTU) ? MC : DC;
    bus.MDUop = op;
    bus.dataA = a;
    bus.dataB = b;
    tick;
    bus.MDUop = NONE;
    bus.dataA = $urandom;
    bus.dataB = $urandom;
    model(op, a, b);
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      n++;
      if (n == 2) begin
        check({tag, "_hold_hi"}, bus.HI, hi_old);
        check({tag, "_hold_lo"}, bus.LO, lo_old);
      end
      if (inject) begin
        if (n == 2)          bus.MDUop = MULT;
        else if (n == 3)     bus.MDUop = MTHI;
        else if (n == exp_n) bus.MDUop = MTLO;
        else                 bus.MDUop = NONE;
      end
      tick;
    end
    bus.MDUop = NONE;
    check({tag, "_busy_len"}, 32'(n), 32'(exp_n));
    check({tag, "_hi"}, bus.HI, hi_m);
    check({tag, "_lo"}, bus.LO, lo_m);
    $display("op %0d a=%h b=%h inj=%0d busy=%0d HI=%h LO=%h", op, a, b, inject, n, bus.HI, bus.LO);
  endtask

  // Single-edge ops (mthi/mtlo/none): no busy cycle, immediate effect.
  task automatic issue_imm(input logic [2:0] op, input logic [31:0] a, input string tag);
    bus.MDUop = op;
    bus.dataA = a;
    bus.dataB = $urandom;
    tick;
    bus.MDUop = NONE;
    model(op, a, 32'd0);
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_hi"}, bus.HI, hi_m);
    check({tag, "_lo"}, bus.LO, lo_m);
    $display("op %0d a=%h HI=%h LO=%h", op, a, bus.HI, bus.LO);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 32'($urandom_range(0, 20));
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0] op;
    logic [31:0] a, b;
    bus.MDUop = NONE;
    bus.dataA = 32'd0;
    bus.dataB = 32'd0;
    reset = 1'b0;
    tick;
    tick;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_hi", bus.HI, 32'd0);
    check("rst_lo", bus.LO, 32'd0);

    reset = 1'b1;
    run_op(MULT, 32'hFFFF_FFFF, 32'd2, "s_mult", 1'b0);
    run_op(MULTU, 32'hFFFF_FFFF, 32'd2, "s_multu", 1'b0);
    run_op(DIV, 32'hFFFF_FFF9, 32'd2, "s_div", 1'b0);
    issue_imm(MTHI, 32'h0000_1234, "s_mthi");
    issue_imm(MTLO, 32'h0000_5678, "s_mtlo");
    run_op(DIVU, 32'd7, 32'd0, "s_divu0", 1'b0);
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, "s_div_ovf", 1'b0);
    run_op(DIV, 32'd100, 32'd7, "s_div_inject", 1'b1);
    issue_imm(BAD, 32'hDEAD_BEEF, "s_op7");

    // Reset in the middle of a multiply aborts it and clears HI/LO.
    bus.MDUop = MULT;
    bus.dataA = 32'd3;
    bus.dataB = 32'd4;
    tick;
    bus.MDUop = NONE;
    tick;
    tick;
    reset = 1'b0;
    tick;
    reset = 1'b1;
    hi_m = 32'd0;
    lo_m = 32'd0;
    check("s_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("s_rst_hi", bus.HI, 32'd0);
    check("s_rst_lo", bus.LO, 32'd0);
    $display("reset mid-run busy=%0d HI=%h LO=%h", bus.busy, bus.HI, bus.LO);
    run_op(MULT, 32'd3, 32'd4, "s_mult_after_rst", 1'b0);

    issue_imm(MTLO, 32'hAAAA_5555, "s_mtlo2");
    run_op(MULT, 32'd1, 32'd1, "s_b2b_mult", 1'b0);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a = rnd_operand();
      b = rnd_operand();
      if (op >= MULT && op <= DIVU)
        run_op(op, a, b, $sformatf("rnd%0d", i), 1'($urandom_range(0, 1)));
      else
        issue_imm(op, a, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 The block SHALL have parameter MULT_CYCLES, default 5, the busy duration of mult/multu in cycles (legal range 1..15).
REQ-002 The block SHALL have parameter DIV_CYCLES, default 10, the busy duration of div/divu in cycles (legal range 1..15).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, a synchronous active-low reset: reset=0 at a rising edge of clk resets the block.
REQ-005 The block SHALL have port dataA, input, 32 bits, operand rs (multiplicand/dividend, or the mthi/mtlo source).
REQ-006 The block SHALL have port dataB, input, 32 bits, operand rt (multiplier/divisor).
REQ-007 The block SHALL have port MDUop, input, 3 bits, encoded 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo; 111 is treated as none.
REQ-008 The block SHALL have port busy, output, 1 bit, high while an operation is in flight.
REQ-009 The block SHALL have port HI, output, 32 bits, the architectural HI register.
REQ-010 The block SHALL have port LO, output, 32 bits, the architectural LO register.

Function
REQ-011 The block SHALL be a two-state FSM: IDLE and RUN, with a 4-bit down-counter cnt.
REQ-012 In IDLE at an edge where MDUop is mult or multu, the block SHALL latch dataA, dataB and the op, load cnt=MULT_CYCLES, and enter RUN.
REQ-013 In IDLE at an edge where MDUop is div or divu, the block SHALL latch dataA, dataB and the op, load cnt=DIV_CYCLES, and enter RUN.
REQ-014 busy SHALL be 1 exactly when the state is RUN; it is registered, with no combinational path from MDUop.
REQ-015 In RUN the block SHALL decrement cnt by 1 at each edge; at the edge where cnt==1 it SHALL write the result to HI/LO, return to IDLE, and clear busy.
REQ-016 Consequently, an op accepted at edge E0 SHALL hold busy=1 for exactly N cycles, and the new HI/LO SHALL be visible after edge E0+N (N=MULT_CYCLES or DIV_CYCLES).
REQ-017 HI/LO SHALL hold their old values throughout RUN; no partial results are ever visible.
REQ-018 mult SHALL compute the 64-bit signed product of the latched operands, with {HI,LO}=product.
REQ-019 multu SHALL compute the 64-bit unsigned product of the latched operands, with {HI,LO}=product.
REQ-020 div SHALL set LO=signed quotient truncated toward zero and HI=remainder carrying the dividend's sign.
REQ-021 divu SHALL set LO=unsigned quotient and HI=unsigned remainder.
REQ-022 For div or divu with a divisor of 0, the block SHALL still run the full DIV_CYCLES with busy high, and HI/LO SHALL remain unchanged.
REQ-023 For div with 0x80000000 / 0xFFFFFFFF, the block SHALL produce LO=0x80000000 and HI=0 (wrap, no trap).
REQ-024 mthi in IDLE SHALL set HI=dataA at that edge with no busy cycle; mtlo in IDLE SHALL set LO=dataA likewise.
REQ-025 Any nonzero MDUop presented while busy=1 SHALL be ignored entirely: no latch, no restart, no HI/LO write, and cnt continues unchanged.
REQ-026 A new op presented in the same cycle that busy is high for the final time (cnt==1) SHALL also be ignored; the earliest acceptance is the edge after busy reads 0.
REQ-027 Back-to-back ops in IDLE SHALL be accepted on consecutive edges (for example, mtlo then mult).
REQ-028 Operand changes on dataA/dataB after acceptance SHALL NOT affect the result.

Reset
REQ-029 When reset=0 at an edge, the block SHALL set state=IDLE, cnt=0, busy=0, HI=0, LO=0 and clear the latched operands; this takes priority over any MDUop.
REQ-030 A reset in the middle of RUN SHALL abort the operation: no result is written, and HI=LO=0 after that edge.
REQ-031 The first op SHALL be accepted at the first edge with reset=1.

Verification
REQ-032 Scenario: after reset, mult with dataA=0xFFFFFFFF, dataB=2 -> busy high for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
REQ-033 Scenario: multu with dataA=0xFFFFFFFF, dataB=2 -> after 5 cycles, HI=0x00000001, LO=0xFFFFFFFE.
REQ-034 Scenario: div with dataA=0xFFFFFFF9 (-7), dataB=2 -> busy high for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; and divu with dataA=7, dataB=0 after mthi 0x1234 / mtlo 0x5678 -> HI=0x1234, LO=0x5678 unchanged after 10 busy cycles.
REQ-035 Scenario: during a div, present mult and mthi while busy=1 -> both ignored, only the div result lands, and busy falls exactly 10 cycles after the div edge.
REQ-036 Scenario: start mult with dataA=3, dataB=4, pull reset=0 at cycle 3 -> busy=0, HI=LO=0; then after reset is released, mult with 3, 4 -> LO=12, HI=0.
REQ-037 Scenario: mtlo dataA=0xAAAA5555, then mult with 1, 1 on the next edge -> LO=0xAAAA5555 visible during RUN, then LO=1 and HI=0.
